mod_n_updown_counter: RTL

Parametrised synchronous modulo-N up/down counter, successor to the fixed 4-bit decade counter.
- Adds: configurable width and modulus, up/down direction, synchronous clear, load priority independent of the enables, terminal-count cascade output, and a registered wrap pulse.
- Used as the building block for multi-digit BCD/time-base chains, with TC feeding the next stage's ENT.

---
 rtl/cnt_pkg.sv | 12 +
 rtl/mod_n_next.sv | 45 ++++
 rtl/mod_n_updown_counter.sv | 65 ++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the modulo-N counter family: direction encoding and
// modulus helpers used by the counter and its next-state logic.
package cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int max_val(input int modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-count logic for a modulo-N up/down counter. Any value
// outside the count sequence recovers in one step and reports a wrap.
module mod_n_next
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ud,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_val(MODULUS));
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // One extra bit keeps the compares clean when MODULUS == 2**WIDTH.
  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] max_ext;

  assign q_ext   = {1'b0, q};
  assign max_ext = {1'b0, MAX_Q};

  always_comb begin
    next = '0;
    wrap = 1'b0;
    if (ud == DIR_UP) begin
      if (q_ext >= max_ext) begin
        next = '0;
        wrap = 1'b1;
      end else begin
        next = q + ONE;
      end
    end else begin
      if (q_ext == '0 || q_ext > max_ext) begin
        next = MAX_Q;
        wrap = 1'b1;
      end else begin
        next = q - ONE;
      end
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with synchronous clear, parallel
// load, 74x161-style TC cascade output and a registered wrap pulse.
module mod_n_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLR,
  input  logic             LD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UD,
  input  logic [WIDTH-1:0] PRE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH %0d outside 1..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_val(MODULUS));

  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;

  mod_n_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q    (Q),
    .ud   (UD),
    .next (nxt),
    .wrap (nxt_wrap)
  );

  // TC ignores ENP so a cascade's upper stages see the carry while the chain is paused.
  assign TC = ENT & (((UD == DIR_UP) & (Q == MAX_Q)) | ((UD == DIR_DN) & (Q == '0)));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else if (SCLR) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else if (LD) begin
      Q    <= PRE;
      WRAP <= 1'b0;
    end else if (ENP && ENT) begin
      Q    <= nxt;
      WRAP <= nxt_wrap;
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule
